deserializer_framed: RTL and testbench

Parametrised serial-to-parallel converter, successor to the fixed 8-bit de-serializer. It collects `DATA_WIDTH` qualified serial bits into a word, with selectable bit order. Frames are explicitly delimited, and an optional parity bit is checked. Each word is presented on a valid/ready output so that downstream logic can stall without losing alignment. It sits between the serial line front-end and the parallel datapath.

---
 rtl/deser_pkg.sv | 19 +
 rtl/deser_out_reg.sv | 66 ++++++
 rtl/deserializer_framed.sv | 127 ++++++++++++
 tb/tb_deserializer_framed.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for the framed deserializer.
package deser_pkg;

  // Frame FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int PARITY_MAX_W = 64;

  // Expected parity bit for a word: XOR of all data bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Output holding register: one word with valid/ready, parity flag and overrun pulse.
// Handshake: a word transfers on any clock edge where valid_o and ready_i are both
// high; while valid_o is high and ready_i low, data_o and perr_o hold steady.
module deser_out_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] word_i,
  input  logic         perr_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         perr_o,
  output logic         overrun_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         perr_q, perr_d;
  logic         ovr_q, ovr_d;
  logic         can_load;

  // Decide whether a completed word loads, is dropped, or the register just drains.
  always_comb begin
    can_load = !valid_q || ready_i;
    data_d   = data_q;
    perr_d   = perr_q;
    valid_d  = valid_q;
    ovr_d    = 1'b0;
    if (load_i && can_load) begin
      data_d  = word_i;
      perr_d  = perr_i;
      valid_d = 1'b1;
    end else begin
      if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
      if (load_i) begin
        ovr_d = 1'b1;
      end
    end
  end

  // Holding register state; reset discards any pending word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign perr_o    = perr_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/deserializer_framed.sv
// Framed serial-to-parallel converter with optional parity and a valid/ready output.
module deserializer_framed
  import deser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 0,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  overrun,
  output logic                  busy,
  output deser_state_t          dbg_state
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  deser_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] first_word, shifted, word;
  logic                  word_done, word_perr;

  // Placement of a frame's first bit and the per-bit shift, by bit order.
  always_comb begin
    if (LSB_FIRST != 0) begin
      first_word = {serial_in, {(DATA_WIDTH-1){1'b0}}};
      shifted    = {serial_in, shreg_q[DATA_WIDTH-1:1]};
    end else begin
      first_word = {{(DATA_WIDTH-1){1'b0}}, serial_in};
      shifted    = {shreg_q[DATA_WIDTH-2:0], serial_in};
    end
  end

  // Frame FSM next state; frame_start always restarts the frame (resync).
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    word_done = 1'b0;
    word      = shreg_q;
    word_perr = 1'b0;
    if (serial_valid) begin
      if (frame_start) begin
        state_d   = SHIFT;
        shreg_d   = first_word;
        bit_cnt_d = ONE;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          SHIFT: begin
            shreg_d = shifted;
            if (bit_cnt_q == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state_d   = PARITY;
                bit_cnt_d = bit_cnt_q + ONE;
              end else begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                word_done = 1'b1;
                word      = shifted;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + ONE;
            end
          end
          PARITY: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            word_done = 1'b1;
            word      = shreg_q;
            word_perr = serial_in != calc_parity(PARITY_MAX_W'(shreg_q), PARITY_ODD != 0);
          end
          default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end
        endcase
      end
    end
  end

  // FSM, shift register, bit counter and registered busy flag.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  deser_out_reg #(.W(DATA_WIDTH)) u_out_reg (
    .clk_i     (clock_in),
    .rst_i     (reset),
    .load_i    (word_done),
    .word_i    (word),
    .perr_i    (word_perr),
    .ready_i   (data_ready),
    .data_o    (data_out),
    .valid_o   (data_valid),
    .perr_o    (parity_err),
    .overrun_o (overrun)
  );

  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_deserializer_framed.sv
// Bench for deserializer_framed: four parameterisations share one input stream.
// Index 0 = MSB-first, 1 = LSB-first, 2 = even parity, 3 = odd parity.
module tb_deserializer_framed;
  import deser_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0;
  logic sv  = 1'b0;
  logic fs  = 1'b0;
  logic rdy = 1'b0;

  logic [7:0]   dout [4];
  logic         dval [4];
  logic         perr [4];
  logic         ovr  [4];
  logic         bsy  [4];
  deser_state_t dbg  [4];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         sel;
    int         nbits;
    logic [8:0] bits;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [9];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  deserializer_framed #(.DATA_WIDTH(8), .LSB_FIRST(0), .PARITY_EN(0), .PARITY_ODD(0)) u_msb (
    .clock_in(clk), .reset(rst), .serial_in(sin), .serial_valid(sv), .frame_start(fs),
    .data_out(dout[0]), .data_valid(dval[0]), .data_ready(rdy), .parity_err(perr[0]),
    .overrun(ovr[0]), .busy(bsy[0]), .dbg_state(dbg[0]));

  deserializer_framed #(.DATA_WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u_lsb (
    .clock_in(clk), .reset(rst), .serial_in(sin), .serial_valid(sv), .frame_start(fs),
    .data_out(dout[1]), .data_valid(dval[1]), .data_ready(rdy), .parity_err(perr[1]),
    .overrun(ovr[1]), .busy(bsy[1]), .dbg_state(dbg[1]));

  deserializer_framed #(.DATA_WIDTH(8), .LSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clock_in(clk), .reset(rst), .serial_in(sin), .serial_valid(sv), .frame_start(fs),
    .data_out(dout[2]), .data_valid(dval[2]), .data_ready(rdy), .parity_err(perr[2]),
    .overrun(ovr[2]), .busy(bsy[2]), .dbg_state(dbg[2]));

  deserializer_framed #(.DATA_WIDTH(8), .LSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clock_in(clk), .reset(rst), .serial_in(sin), .serial_valid(sv), .frame_start(fs),
    .data_out(dout[3]), .data_valid(dval[3]), .data_ready(rdy), .parity_err(perr[3]),
    .overrun(ovr[3]), .busy(bsy[3]), .dbg_state(dbg[3]));

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, the rising edge samples them
  task automatic drive_bit(input logic b, input logic f);
    @(negedge clk);
    sv  = 1'b1;
    sin = b;
    fs  = f;
  endtask

  task automatic idle();
    @(negedge clk);
    sv  = 1'b0;
    sin = 1'b0;
    fs  = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      drive_bit(bits[i], i == nbits - 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sv  = 1'b0;
    fs  = 1'b0;
    sin = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 8, 9'h0A3, 8'hA3, 1'b0};
    vecs[1] = '{1, 8, 9'h0A3, 8'hC5, 1'b0};
    vecs[2] = '{2, 9, {8'hA3, 1'b0}, 8'hA3, 1'b0};
    vecs[3] = '{2, 9, {8'hA3, 1'b1}, 8'hA3, 1'b1};
    vecs[4] = '{3, 9, {8'hA3, 1'b1}, 8'hA3, 1'b0};
    vecs[5] = '{3, 9, {8'hA3, 1'b0}, 8'hA3, 1'b1};
    vecs[6] = '{0, 8, 9'h05C, 8'h5C, 1'b0};
    vecs[7] = '{1, 8, 9'h00F, 8'hF0, 1'b0};
    vecs[8] = '{2, 9, {8'h5C, 1'b1}, 8'h5C, 1'b1};

    // reset state of every instance
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_dout%0d", k), 32'(dout[k]), 32'h0);
      chk($sformatf("rst_dval%0d", k), 32'(dval[k]), 32'h0);
      chk($sformatf("rst_perr%0d", k), 32'(perr[k]), 32'h0);
      chk($sformatf("rst_ovr%0d", k),  32'(ovr[k]),  32'h0);
      chk($sformatf("rst_busy%0d", k), 32'(bsy[k]),  32'h0);
    end
    rst = 1'b0;

    // table-driven single frames
    for (int v = 0; v < 9; v++) begin
      do_reset();
      send_frame(vecs[v].bits, vecs[v].nbits);
      idle();
      chk($sformatf("v%0d_dout", v), 32'(dout[vecs[v].sel]), 32'(vecs[v].exp_data));
      chk($sformatf("v%0d_dval", v), 32'(dval[vecs[v].sel]), 32'h1);
      chk($sformatf("v%0d_perr", v), 32'(perr[vecs[v].sel]), 32'(vecs[v].exp_perr));
      rdy = 1'b1;
      idle();
      chk($sformatf("v%0d_drain", v), 32'(dval[vecs[v].sel]), 32'h0);
      rdy = 1'b0;
    end

    // overrun: stalled output, second word dropped, third loads on the consume edge
    do_reset();
    send_frame(9'h0A3, 8);
    send_frame(9'h05C, 8);
    idle();
    chk("ovr_pulse", 32'(ovr[0]), 32'h1);
    chk("ovr_dout", 32'(dout[0]), 32'hA3);
    chk("ovr_dval", 32'(dval[0]), 32'h1);
    idle();
    chk("ovr_one_cycle", 32'(ovr[0]), 32'h0);
    chk("ovr_hold", 32'(dout[0]), 32'hA3);
    for (int i = 7; i >= 1; i--) begin
      drive_bit(i >= 4 ? 1'b0 : 1'b1, i == 7);
    end
    drive_bit(1'b1, 1'b0);
    rdy = 1'b1;
    idle();
    chk("ovr3_dval", 32'(dval[0]), 32'h1);
    chk("ovr3_dout", 32'(dout[0]), 32'h0F);
    chk("ovr3_noovr", 32'(ovr[0]), 32'h0);
    idle();
    chk("ovr3_drain", 32'(dval[0]), 32'h0);
    rdy = 1'b0;

    // resync: partial frame discarded, restart on frame_start
    do_reset();
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    chk("rs_busy", 32'(bsy[0]), 32'h1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive_bit(i >= 3 ? 1'b1 : 1'b0, 1'b0);
    end
    chk("rs_no_early", 32'(dval[0]), 32'h0);
    idle();
    chk("rs_dout", 32'(dout[0]), 32'h0F);
    chk("rs_dval", 32'(dval[0]), 32'h1);
    chk("rs_dout_lsb", 32'(dout[1]), 32'hF0);
    chk("rs_state", 32'(dbg[0]), 32'(IDLE));
    rdy = 1'b1;
    idle();
    rdy = 1'b0;
    chk("rs_drain", 32'(dval[0]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(1'b1, 1'b0);
    end
    idle();
    chk("idle_ignore_dval", 32'(dval[0]), 32'h0);
    chk("idle_ignore_busy", 32'(bsy[0]), 32'h0);

    // reset mid-frame with a pending word
    do_reset();
    send_frame(9'h0A3, 8);
    for (int i = 7; i >= 4; i--) begin
      drive_bit(i == 6 || i == 4 ? 1'b1 : 1'b0, i == 7);
    end
    @(negedge clk);
    sv = 1'b0;
    fs = 1'b0;
    chk("mid_pending", 32'(dval[0]), 32'h1);
    chk("mid_busy", 32'(bsy[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_dout", 32'(dout[0]), 32'h0);
    chk("mid_dval", 32'(dval[0]), 32'h0);
    chk("mid_busy_clr", 32'(bsy[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(9'h05C, 8);
    idle();
    chk("post_dout", 32'(dout[0]), 32'h5C);
    chk("post_dval", 32'(dval[0]), 32'h1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
